// File: rtl/rs232_rx_fifo.sv
// Buffered RS-232 receiver: 2-FF synchronizer, 8N1 deframer and a first-word-fall-through byte FIFO.
// Define RS232_RX_PARITY_EN for 8E1 framing with a functional perr flag.
module rs232_rx_fifo #(
    parameter int CLK_HZ    = 25000000,
    parameter int BAUD_SLOW = 19200,
    parameter int BAUD_FAST = 115200,
    parameter int AW        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RxD,
    input  logic        fsel,
    input  logic        done,
    input  logic        clr,
    output logic [7:0]  data,
    output logic        rdy,
    output logic [AW:0] count,
    output logic        ovf,
    output logic        ferr,
    output logic        perr
);
    localparam int T_SLOW = CLK_HZ / BAUD_SLOW;
    localparam int T_FAST = CLK_HZ / BAUD_FAST;
    localparam int T_MAX  = (T_SLOW > T_FAST) ? T_SLOW : T_FAST;
    localparam int TW     = $clog2(T_MAX + 1);
    localparam int DEPTH  = 1 << AW;
    localparam logic [TW-1:0] BIT_SLOW  = TW'(T_SLOW - 1);
    localparam logic [TW-1:0] BIT_FAST  = TW'(T_FAST - 1);
    localparam logic [TW-1:0] HALF_SLOW = TW'(T_SLOW / 2 - 1);
    localparam logic [TW-1:0] HALF_FAST = TW'(T_FAST / 2 - 1);
    localparam logic [AW:0]   FULL      = {1'b1, {AW{1'b0}}};

`ifdef RS232_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE_WAIT, IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE_WAIT, IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic          rx_meta_q, rxs_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          fsel_q, fsel_d;
    logic          tick;
    logic [TW-1:0] bit_len;
    logic          push, set_ferr;
`ifdef RS232_RX_PARITY_EN
    logic          par_ok_q, par_ok_d, set_perr, perr_q, perr_d;
`endif

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    data_q, data_d;
    logic          ovf_q, ovf_d, ferr_q, ferr_d;
    logic          pop, push_ok, set_ovf;

    assign tick    = (timer_q == '0);
    assign bit_len = fsel_q ? BIT_FAST : BIT_SLOW;

    // Synchronizer resets to idle-high so reset never fakes a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= IDLE_WAIT;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            fsel_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_ok_q  <= 1'b1;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= RxD;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            fsel_q    <= fsel_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            ferr_q    <= ferr_d;
`ifdef RS232_RX_PARITY_EN
            par_ok_q  <= par_ok_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_WAIT: if (rxs_q) state_d = IDLE;
            IDLE:      if (!rxs_q) state_d = START;
            START:     if (tick) state_d = rxs_q ? IDLE : DATA;
`ifdef RS232_RX_PARITY_EN
            DATA:      if (tick && bit_cnt_q == 3'd7) state_d = PARITY;
            PARITY:    if (tick) state_d = STOP;
`else
            DATA:      if (tick && bit_cnt_q == 3'd7) state_d = STOP;
`endif
            STOP:      if (tick) state_d = rxs_q ? IDLE : IDLE_WAIT;
            default:   state_d = IDLE_WAIT;
        endcase
    end

    always_comb begin
        timer_d   = tick ? timer_q : timer_q - TW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        fsel_d    = fsel_q;
        push      = 1'b0;
        set_ferr  = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_ok_d  = par_ok_q;
        set_perr  = 1'b0;
`endif
        case (state_q)
            IDLE: if (!rxs_q) begin
                fsel_d    = fsel;
                timer_d   = fsel ? HALF_FAST : HALF_SLOW;
                bit_cnt_d = '0;
            end
            START: if (tick && !rxs_q) timer_d = bit_len;
            DATA: if (tick) begin
                shift_d   = {rxs_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                timer_d   = bit_len;
            end
`ifdef RS232_RX_PARITY_EN
            PARITY: if (tick) begin
                par_ok_d = (rxs_q == ^shift_q);
                timer_d  = bit_len;
            end
            STOP: if (tick) begin
                set_ferr = !rxs_q;
                push     = rxs_q && par_ok_q;
                set_perr = rxs_q && !par_ok_q;
            end
`else
            STOP: if (tick) begin
                set_ferr = !rxs_q;
                push     = rxs_q;
            end
`endif
            default: ;
        endcase
    end

    // A pop on a full FIFO frees the slot for a same-cycle push; a pop on empty is ignored.
    always_comb begin
        pop      = done && (count_q != '0);
        push_ok  = push && ((count_q != FULL) || pop);
        set_ovf  = push && (count_q == FULL) && !pop;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        if (count_d == '0)
            data_d = 8'h00;
        else if (push_ok && (wr_ptr_q == rd_ptr_d))
            data_d = shift_q;
        else
            data_d = mem_q[rd_ptr_d];
        ovf_d  = (ovf_q & ~clr) | set_ovf;
        ferr_d = (ferr_q & ~clr) | set_ferr;
`ifdef RS232_RX_PARITY_EN
        perr_d = (perr_q & ~clr) | set_perr;
`endif
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign data  = data_q;
    assign rdy   = (count_q != '0);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign ferr  = ferr_q;
`ifdef RS232_RX_PARITY_EN
    assign perr  = perr_q;
`else
    assign perr  = 1'b0;
`endif
endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed-plus-random bench for rs232_rx_fifo; frames are bit-banged on RxD and the
// FIFO contents and sticky flags are predicted with a byte queue and three flag bits.
module tb_rs232_rx_fifo;
    localparam int T_S = 25000000 / 19200;
    localparam int T_F = 25000000 / 115200;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst, RxD, fsel, done, clr;
    logic [7:0] data;
    logic       rdy, ovf, ferr, perr;
    logic [4:0] count;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0, exp_ferr = 1'b0, exp_perr = 1'b0;

    always #5 clk = ~clk;

    rs232_rx_fifo #(.AW(4)) dut (
        .clk(clk), .rst(rst), .RxD(RxD), .fsel(fsel), .done(done), .clr(clr),
        .data(data), .rdy(rdy), .count(count), .ovf(ovf), .ferr(ferr), .perr(perr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int bit_time();
        return fsel ? T_F : T_S;
    endfunction

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
        chk({tag, "_rdy"}, 32'(rdy), 32'(exp_q.size() != 0));
        chk({tag, "_data"}, 32'(data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, "_ferr"}, 32'(ferr), 32'(exp_ferr));
        chk({tag, "_perr"}, 32'(perr), 32'(exp_perr));
    endtask

    // Frame on RxD; with pop_at_stop, done is high exactly in the cycle the stop bit is
    // sampled: 2 synchronizer cycles + half bit + 9 bit times (10 with parity) after the start edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v,
                              input logic pop_at_stop);
        int t;
        int h;
        t = bit_time();
        h = t / 2;
        @(posedge clk);
        #1;
        RxD = 1'b0;
        wait_cyc(t);
        for (int j = 0; j < 8; j++) begin
            RxD = b[j];
            wait_cyc(t);
        end
`ifdef RS232_RX_PARITY_EN
        RxD = par_v;
        wait_cyc(t);
`else
        if (par_v === 1'bx) RxD = 1'b1;
`endif
        RxD = stop_v;
        if (pop_at_stop) begin
            wait_cyc(h + 2);
            if (exp_q.size() != 0) chk("pop_at_stop_head", 32'(data), 32'(exp_q[0]));
            done = 1'b1;
            wait_cyc(1);
            done = 1'b0;
            wait_cyc(t - h - 3);
        end else begin
            wait_cyc(t);
        end
        RxD = 1'b1;
    endtask

    task automatic recv(input logic [7:0] b, input logic pop_at_stop);
        send_frame(b, 1'b1, ^b, pop_at_stop);
        if (pop_at_stop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    task automatic pop_one(input string tag);
        check_state(tag);
        @(posedge clk);
        #1;
        done = 1'b1;
        wait_cyc(1);
        done = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1;
        clr = 1'b1;
        wait_cyc(1);
        clr = 1'b0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        rst = 1'b0; RxD = 1'b1; fsel = 1'b0; done = 1'b0; clr = 1'b0;
        repeat (4) @(posedge clk);
        check_state("reset");
        #1 rst = 1'b1;
        wait_cyc(3);

        // single byte at the slow rate, then pop
        recv(8'h55, 1'b0);
        check_state("t1_rx");
        pop_one("t1_pop");
        check_state("t1_empty");

        // back-to-back frames at the fast rate
        fsel = 1'b1;
        recv(8'h00, 1'b0);
        recv(8'hFF, 1'b0);
        recv(8'hA5, 1'b0);
        check_state("t2_three");
        for (int i = 0; i < 3; i++) pop_one("t2_pop");
        check_state("t2_empty");

        // overflow: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) recv(8'($urandom_range(0, 255)), 1'b0);
        check_state("t3_full");
        pulse_clr();
        check_state("t3_clr");

        // push while full with a pop in the stop-sample cycle
        recv(8'($urandom_range(0, 255)), 1'b1);
        check_state("t4_full");
        for (int i = 0; i < DEPTH; i++) pop_one("t4_pop");
        check_state("t4_empty");

        // start-bit glitch at the slow rate, then framing error, then a good byte
        fsel = 1'b0;
        @(posedge clk);
        #1 RxD = 1'b0;
        wait_cyc(300);
        RxD = 1'b1;
        wait_cyc(1500);
        check_state("t5_glitch");
        fsel = 1'b1;
        send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
        wait_cyc(20);
        exp_ferr = 1'b1;
        check_state("t5_ferr");
        recv(8'h96, 1'b0);
        check_state("t5_good");

        // reset in the middle of data bit 5 of 0xF0; the remaining bits are high
        @(posedge clk);
        #1 RxD = 1'b0;
        wait_cyc(T_F);
        for (int j = 0; j < 5; j++) begin
            RxD = (j >= 4);
            wait_cyc(T_F);
        end
        RxD = 1'b1;
        wait_cyc(T_F / 2);
        rst = 1'b0;
        wait_cyc(2);
        rst = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0; exp_ferr = 1'b0; exp_perr = 1'b0;
        check_state("t6_reset");
        wait_cyc(4 * T_F);
        check_state("t6_nostray");

`ifdef RS232_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1, 1'b0);
        exp_perr = 1'b1;
        check_state("t6_perr");
        pulse_clr();
        check_state("t6_perr_clr");
        recv(8'h03, 1'b0);
        check_state("t6_par_ok");
        pop_one("t6_par_pop");
`endif

        // random bursts with random drains
        for (int r = 0; r < 2; r++) begin
            n = $urandom_range(1, 2);
            for (int i = 0; i < n; i++) recv(8'($urandom_range(0, 255)), 1'b0);
            k = $urandom_range(0, exp_q.size());
            for (int i = 0; i < k; i++) pop_one("rnd_pop");
            check_state("rnd_after");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
